// File: rtl/program_loader_if.sv
// program_loader_if: byte-stream input and instruction-write/status output bundle of the program loader.
interface program_loader_if #(parameter int WORD_ADDR_WIDTH = 14);
  logic byte_valid;
  logic [7:0] byte_data;
  logic byte_ready;
  logic instruction_write;
  logic [31:0] instruction_in;
  logic debug_enable;
  logic loading;
  logic done;
  logic error;
  logic [WORD_ADDR_WIDTH:0] words_written;
  modport master (
    input byte_valid, byte_data,
    output byte_ready, instruction_write, instruction_in, debug_enable, loading, done, error, words_written
  );
  modport slave (
    output byte_valid, byte_data,
    input byte_ready, instruction_write, instruction_in, debug_enable, loading, done, error, words_written
  );
endinterface

// File: rtl/program_loader.sv
// program_loader: packs a MAGIC/COUNT/words byte stream into 32-bit instruction writes, stalling the core until loaded.
// Optional PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte checked before release.
module program_loader #(
  parameter int WORD_ADDR_WIDTH = 14,
  parameter logic [7:0] MAGIC = 8'hA5,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic clk,
  input logic rst,
  program_loader_if.master bus
);
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, RUN, ERROR
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    , CHK
`endif
  } state_t;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam state_t FIN = CHK;
  logic [7:0] csum;
`else
  localparam state_t FIN = RUN;
`endif
  state_t state, nxt;
  logic [15:0] count, cnt_in;
  logic [23:0] shift;
  logic [1:0] idx;
  logic [TW-1:0] idle_cnt;
  logic xfer, last, wr, timeout;
  assign xfer = bus.byte_valid & bus.byte_ready;
  assign cnt_in = {bus.byte_data, count[7:0]};
  // last: every word has been strobed; this cycle carries the final strobe
  assign last = state == DATA && 32'(bus.words_written) == 32'(count);
  assign wr = state == DATA && !last && xfer && idx == 2'd3;
  assign timeout = TIMEOUT_CYCLES != 0 && bus.loading && !xfer && !last && 32'(idle_cnt) == 32'(TIMEOUT_CYCLES - 1);
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = xfer && bus.byte_data == MAGIC ? CNT_LO : IDLE;
      CNT_LO: nxt = xfer ? CNT_HI : CNT_LO;
      CNT_HI: nxt = !xfer ? CNT_HI : {16'd0, cnt_in} > (32'd1 << WORD_ADDR_WIDTH) ? ERROR : cnt_in == '0 ? FIN : DATA;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      DATA: nxt = !last ? DATA : !xfer ? CHK : bus.byte_data == csum ? RUN : ERROR;
      CHK: nxt = !xfer ? CHK : bus.byte_data == csum ? RUN : ERROR;
`else
      DATA: nxt = last ? RUN : DATA;
`endif
      default: nxt = state;
    endcase
    if (timeout) nxt = ERROR;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      shift <= '0;
      idx <= '0;
      idle_cnt <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum <= '0;
`endif
      bus.byte_ready <= 1'b0;
      bus.instruction_write <= 1'b0;
      bus.instruction_in <= '0;
      bus.debug_enable <= 1'b0;
      bus.loading <= 1'b0;
      bus.done <= 1'b0;
      bus.error <= 1'b0;
      bus.words_written <= '0;
    end else begin
      state <= nxt;
      idle_cnt <= xfer || !bus.loading ? '0 : idle_cnt + 1'b1;
      if (state == CNT_LO && xfer) count[7:0] <= bus.byte_data;
      if (state == CNT_HI && xfer) count <= cnt_in;
      if (state == DATA && !last && xfer) begin
        shift <= {bus.byte_data, shift[23:8]};
        idx <= idx + 1'b1;
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      if (state == IDLE && xfer && bus.byte_data == MAGIC) csum <= '0;
      else if (state == DATA && !last && xfer) csum <= csum ^ bus.byte_data;
`endif
      bus.instruction_write <= wr;
      if (wr) begin
        bus.instruction_in <= {bus.byte_data, shift};
        bus.words_written <= bus.words_written + 1'b1;
      end
      bus.byte_ready <= nxt != ERROR;
      bus.debug_enable <= nxt == RUN;
      bus.done <= nxt == RUN;
      bus.error <= nxt == ERROR;
      bus.loading <= nxt != IDLE && nxt != RUN && nxt != ERROR;
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench; expected words are queued as bytes are driven and popped on each strobe.
module tb_program_loader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  logic [7:0] csum;
  program_loader_if #(.WORD_ADDR_WIDTH(14)) bus();
  program_loader #(.WORD_ADDR_WIDTH(14), .MAGIC(8'hA5), .TIMEOUT_CYCLES(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic cycle();
    logic [31:0] e;
    @(posedge clk);
    #1;
    if (bus.instruction_write === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL strobe_unexpected: got word %h, expected no strobe", bus.instruction_in);
      end else begin
        e = exp_q.pop_front();
        if (bus.instruction_in !== e) begin
          fails++;
          $display("FAIL strobe_word: got %h want %h", bus.instruction_in, e);
        end
      end
    end
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data = b;
    while (bus.byte_ready !== 1'b1 && n < 20) begin
      cycle();
      n++;
    end
    if (n == 20) begin
      tests++;
      fails++;
      $display("FAIL send_ready: byte_ready %b want 1", bus.byte_ready);
    end
    cycle();
    bus.byte_valid = 1'b0;
  endtask
  task automatic start(input logic [15:0] cnt);
    csum = 8'h00;
    send(8'hA5);
    send(cnt[7:0]);
    send(cnt[15:8]);
  endtask
  task automatic send_word(input logic [31:0] w);
    exp_q.push_back(w);
    for (int i = 0; i < 4; i++) begin
      send(w[8*i +: 8]);
      csum ^= w[8*i +: 8];
    end
  endtask
  task automatic finish_image();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send(csum);
`else
    cycle();
`endif
  endtask
  task automatic do_reset();
    bus.byte_valid = 1'b0;
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_words: got %0d queued want 0", exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic test_reset();
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    rst = 1'b0;
    repeat (2) cycle();
    tests++;
    if ({bus.byte_ready, bus.instruction_write, bus.debug_enable, bus.loading, bus.done, bus.error} !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b want 000000", {bus.byte_ready, bus.instruction_write, bus.debug_enable, bus.loading, bus.done, bus.error});
    end
    tests++;
    if (bus.instruction_in !== 32'h0 || bus.words_written !== '0) begin
      fails++;
      $display("FAIL reset_data: got %h/%0d want 0/0", bus.instruction_in, bus.words_written);
    end
    rst = 1'b1;
    cycle();
    tests++;
    if (bus.byte_ready !== 1'b1 || bus.loading !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: ready/loading %b%b want 10", bus.byte_ready, bus.loading);
    end
  endtask
  task automatic test_basic();
    start(16'd2);
    tests++;
    if (bus.loading !== 1'b1) begin
      fails++;
      $display("FAIL basic_loading: got %b want 1", bus.loading);
    end
    send_word(32'h00000013);
    send_word(32'h00100093);
    tests++;
    if (bus.instruction_write !== 1'b1 || bus.debug_enable !== 1'b0) begin
      fails++;
      $display("FAIL basic_last_strobe: write/debug %b%b want 10", bus.instruction_write, bus.debug_enable);
    end
    finish_image();
    tests++;
    if (bus.debug_enable !== 1'b1 || bus.done !== 1'b1 || bus.loading !== 1'b0) begin
      fails++;
      $display("FAIL basic_run: debug/done/loading %b%b%b want 110", bus.debug_enable, bus.done, bus.loading);
    end
    tests++;
    if (bus.words_written !== 15'd2) begin
      fails++;
      $display("FAIL basic_count: got %0d want 2", bus.words_written);
    end
    send(8'h55);
    tests++;
    if (bus.words_written !== 15'd2 || bus.byte_ready !== 1'b1 || bus.debug_enable !== 1'b1) begin
      fails++;
      $display("FAIL basic_run_ignore: count %0d ready %b debug %b want 2 1 1", bus.words_written, bus.byte_ready, bus.debug_enable);
    end
  endtask
  task automatic test_discard();
    do_reset();
    send(8'h00);
    send(8'hFF);
    tests++;
    if (bus.loading !== 1'b0 || bus.words_written !== '0) begin
      fails++;
      $display("FAIL discard_idle: loading %b count %0d want 0 0", bus.loading, bus.words_written);
    end
    start(16'd1);
    send_word(32'hDEADBEEF);
    finish_image();
    tests++;
    if (bus.debug_enable !== 1'b1 || bus.words_written !== 15'd1) begin
      fails++;
      $display("FAIL discard_run: debug %b count %0d want 1 1", bus.debug_enable, bus.words_written);
    end
  endtask
  task automatic test_overcount();
    do_reset();
    start(16'h4001);
    tests++;
    if (bus.error !== 1'b1 || bus.byte_ready !== 1'b0 || bus.debug_enable !== 1'b0 || bus.loading !== 1'b0) begin
      fails++;
      $display("FAIL over_error: error/ready/debug/loading %b%b%b%b want 1000", bus.error, bus.byte_ready, bus.debug_enable, bus.loading);
    end
    bus.byte_valid = 1'b1;
    bus.byte_data = 8'h11;
    repeat (3) cycle();
    bus.byte_valid = 1'b0;
    tests++;
    if (bus.error !== 1'b1 || bus.words_written !== '0) begin
      fails++;
      $display("FAIL over_sticky: error %b count %0d want 1 0", bus.error, bus.words_written);
    end
    do_reset();
    tests++;
    if (bus.error !== 1'b0 || bus.byte_ready !== 1'b1) begin
      fails++;
      $display("FAIL over_reset: error/ready %b%b want 01", bus.error, bus.byte_ready);
    end
    start(16'h4000);
    tests++;
    if (bus.error !== 1'b0 || bus.loading !== 1'b1) begin
      fails++;
      $display("FAIL max_count: error/loading %b%b want 01", bus.error, bus.loading);
    end
  endtask
  task automatic test_timeout();
    do_reset();
    start(16'd1);
    send(8'hAA);
    send(8'hBB);
    repeat (15) cycle();
    tests++;
    if (bus.error !== 1'b0 || bus.loading !== 1'b1) begin
      fails++;
      $display("FAIL timeout_early: error/loading %b%b want 01", bus.error, bus.loading);
    end
    cycle();
    tests++;
    if (bus.error !== 1'b1 || bus.words_written !== '0 || bus.debug_enable !== 1'b0 || bus.loading !== 1'b0) begin
      fails++;
      $display("FAIL timeout_error: error %b count %0d debug %b loading %b want 1 0 0 0", bus.error, bus.words_written, bus.debug_enable, bus.loading);
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    start(16'd2);
    send_word(32'h11223344);
    send(8'h55);
    send(8'h66);
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({bus.byte_ready, bus.instruction_write, bus.debug_enable, bus.loading, bus.done, bus.error} !== 6'b0 || bus.instruction_in !== 32'h0 || bus.words_written !== '0) begin
      fails++;
      $display("FAIL reset_mid: flags %b word %h count %0d want 0 0 0", {bus.byte_ready, bus.instruction_write, bus.debug_enable, bus.loading, bus.done, bus.error}, bus.instruction_in, bus.words_written);
    end
    cycle();
    rst = 1'b1;
    cycle();
    start(16'd1);
    send_word(32'hCAFEF00D);
    finish_image();
    tests++;
    if (bus.debug_enable !== 1'b1 || bus.words_written !== 15'd1 || bus.instruction_in !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL reset_reload: debug %b count %0d word %h want 1 1 cafef00d", bus.debug_enable, bus.words_written, bus.instruction_in);
    end
  endtask
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    start(16'd1);
    send_word(32'h04030201);
    send(8'h04);
    tests++;
    if (bus.debug_enable !== 1'b1 || bus.error !== 1'b0) begin
      fails++;
      $display("FAIL csum_good: debug/error %b%b want 10", bus.debug_enable, bus.error);
    end
    do_reset();
    start(16'd1);
    send_word(32'h04030201);
    send(8'h05);
    tests++;
    if (bus.error !== 1'b1 || bus.debug_enable !== 1'b0 || bus.done !== 1'b0 || bus.words_written !== 15'd1) begin
      fails++;
      $display("FAIL csum_bad: error %b debug %b done %b count %0d want 1 0 0 1", bus.error, bus.debug_enable, bus.done, bus.words_written);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_basic();
    test_discard();
    test_overcount();
    test_timeout();
    test_reset_mid();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    do_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Initiator side of the instruction-load interface: takes a byte stream from a serial receiver and packs it into 32-bit words.
- Drives instruction_write / instruction_in into the core datapath.
- Holds debug_enable low, stalling the core, until a complete program image has been written.
- Sits between the UART RX front end and the datapath at the top level.

Parameters:
- WORD_ADDR_WIDTH, 14, log2 of instruction RAM depth in words; maximum image = 2**WORD_ADDR_WIDTH words.
- MAGIC, 8'hA5, start-of-image byte.
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between bytes inside an image; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- byte_valid  input  1  byte_data is valid this cycle
- byte_data  input  8  received byte
- byte_ready  output  1  loader accepts byte this cycle
- instruction_write  output  1  one-cycle write strobe to instruction RAM; RAM address auto-increments per strobe
- instruction_in  output  32  word to write
- debug_enable  output  1  core run enable; 0 holds the core stalled
- loading  output  1  image transfer in progress
- done  output  1  image fully written, sticky
- error  output  1  protocol error, sticky
- words_written  output  WORD_ADDR_WIDTH+1  count of strobes issued

Behaviour:
- Reset (rst=0, asynchronous) forces every output to 0 and the state to IDLE. This includes byte_ready, instruction_in and words_written.
- A byte transfer occurs on a rising edge with byte_valid & byte_ready.
- byte_ready = 1 in every state except ERROR and during reset.
- Image format: MAGIC, COUNT_LO, COUNT_HI, then COUNT words. Each word is 4 bytes, least-significant byte first.
- States:
  - IDLE: bytes other than MAGIC are discarded. MAGIC -> CNT_LO.
  - CNT_LO: latch count[7:0] -> CNT_HI.
  - CNT_HI: latch count[15:8].
    - count > 2**WORD_ADDR_WIDTH -> ERROR.
    - count == 0 -> RUN (or CHK when the optional feature is compiled in).
    - Otherwise -> DATA.
  - DATA: a 2-bit byte index shifts each byte into the word buffer.
    - When the 4th byte is accepted on edge N: instruction_write = 1 for exactly the cycle after edge N, and instruction_in = {b3,b2,b1,b0} in that cycle.
    - words_written increments on the same edge.
    - After the last word, the next state is RUN (or CHK).
  - RUN: debug_enable = 1, done = 1, loading = 0.
    - Entered on the edge that ends the final write strobe, so debug_enable rises the cycle after the last strobe.
    - Further bytes are accepted and ignored.
  - ERROR: error = 1, debug_enable = 0, byte_ready = 0. Only reset exits ERROR.
- loading = 1 in CNT_LO, CNT_HI, DATA and CHK.
- instruction_in holds its last value between strobes.
- A strobe can never occur in back-to-back cycles, because a word takes at least 4 accepted bytes.
- Timeout: an idle counter clears on every accepted byte and counts while loading = 1 with no transfer. Reaching TIMEOUT_CYCLES -> ERROR. The counter is inactive in IDLE and RUN.
- Partial word at timeout: no strobe is issued for the partial bytes; words_written is preserved.
- Reset mid-image: everything returns to the reset state, and the next byte stream must restart with MAGIC.
- Byte_valid asserted in the same cycle a strobe is issued: the byte is accepted normally, with no stall.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Defined:
  - A CHK state follows the final word (or CNT_HI when count == 0).
  - One checksum byte is expected, equal to the XOR of all payload bytes. Header bytes are excluded.
  - Match -> RUN. Mismatch -> ERROR.
  - Words already written remain in RAM, but debug_enable stays 0.
  - The running XOR resets on MAGIC.
- Undefined: no CHK state and no checksum hardware. The last word goes straight to RUN.

Test Plan:
- Stream A5 02 00 13 00 00 00 93 00 10 00 -> strobes with instruction_in = 32'h00000013, then 32'h00100093; words_written = 2; debug_enable rises one cycle after the 2nd strobe; done = 1.
- Bytes 00 FF A5 01 00 EF BE AD DE -> leading 00 FF discarded; single strobe with 32'hDEADBEEF.
- Header A5 01 40 with WORD_ADDR_WIDTH = 14 (count 16385) -> error = 1, byte_ready = 0, no strobes, debug_enable = 0 until rst is pulsed.
- TIMEOUT_CYCLES = 16; send A5 01 00 AA BB, then idle 16 cycles -> error = 1; words_written = 0; no strobe.
- Assert rst low after 2 of 4 data bytes -> all outputs 0 immediately; a fresh valid image then loads correctly from words_written = 0.
- With PROGRAM_LOADER_CHECKSUM_EN: A5 01 00 01 02 03 04 04 -> RUN (checksum 04 correct). The same image with final byte 05 -> one strobe, then error = 1, debug_enable = 0.
